phasecomp: RTL

Oversampled-PFB phase compensator: consumes the per-sample filtered branch sums leaving the PE `datapath` chain (`vout`/`sout`) and re-emits each FFT_LEN-sample frame circularly rotated by an offset that advances by DEC_FAC per frame. This removes the phase rotation caused by oversampling before the FFT. It sits between the polyphase `datapath` and the FFT input. Internally it is ping-pong buffered: one bank is written while the other is read.

---
 rtl/phasecomp_if.sv | 12 +
 rtl/phasecomp.sv | 89 ++++++++
 2 files changed

// File: rtl/phasecomp_if.sv
// Sample stream between the polyphase datapath, the phase compensator and the FFT input.
interface phasecomp_if #(
  parameter int unsigned WIDTH = 16
);
  logic                    vin;
  logic signed [WIDTH-1:0] din;
  logic                    vout;
  logic signed [WIDTH-1:0] dout;

  modport master (output vin, din, input vout, dout);
  modport slave  (input vin, din, output vout, dout);
endinterface

// File: rtl/phasecomp.sv
// Oversampled-PFB phase compensator: ping-pong frame buffer whose readout is
// circularly rotated by an offset that advances by DEC_FAC every frame.
module phasecomp #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned FFT_LEN = 32,
  parameter int unsigned DEC_FAC = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  phasecomp_if.slave  bus
);
  localparam int unsigned    AW   = $clog2(FFT_LEN);
  localparam logic [AW-1:0]  LAST = AW'(FFT_LEN - 1);
  localparam logic [AW-1:0]  DEC  = AW'(DEC_FAC);

  typedef enum logic {IDLE, READ} state_t;

  state_t                  state, state_next;
  logic                    wr_bank, rd_bank;
  logic [AW-1:0]           wr_ctr, rd_ctr, shift, rot, rd_addr;
  logic                    wr_fire, frame_done;
  logic signed [WIDTH-1:0] mem [2*FFT_LEN];
  logic                    vout;
  logic signed [WIDTH-1:0] dout;

  assign bus.vout = vout;
  assign bus.dout = dout;

  // Write strobe, frame-complete detect and rotated read address
  always_comb begin
    wr_fire    = en & bus.vin;
    frame_done = wr_fire && (wr_ctr == LAST);
    rd_addr    = AW'(rd_ctr + rot);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A frame completing on the last read cycle chains straight into the next readout
  always_comb begin
    state_next = state;
    if (en) begin
      unique case (state)
        IDLE: if (frame_done) state_next = READ;
        READ: begin
          if (frame_done)          state_next = READ;
          else if (rd_ctr == LAST) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Storage carries no reset; contents are only read after being written
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank, wr_ctr}] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_ctr  <= '0;
      rd_ctr  <= '0;
      shift   <= '0;
      rot     <= '0;
      vout    <= 1'b0;
      dout    <= '0;
    end else if (en) begin
      vout <= (state == READ);
      if (state == READ) begin
        dout   <= mem[{rd_bank, rd_addr}];
        rd_ctr <= AW'(rd_ctr + 1'b1);
      end
      if (wr_fire) wr_ctr <= AW'(wr_ctr + 1'b1);
      // Hand the just-filled bank to the reader with this frame's rotation
      if (frame_done) begin
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
        rd_ctr  <= '0;
        rot     <= shift;
        shift   <= AW'(shift + DEC);
      end
    end
  end
endmodule
